// File: rtl/fixed_div.sv
// Iterative signed fixed-point divider: result = a / b in Q(INT_DIGIT).(DECIMAL_DIGIT).
// Restoring division, one quotient bit per cycle, valid/ready handshake on both sides.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands valid          in_ready   idle, can accept
//   a, b       signed dividend/divisor (W bits)
//   out_valid  result valid (held)     out_ready  consumer accepts result
//   result     signed quotient (W bits)
//   overflow   quotient outside the W-bit signed range
//   div0       divisor was zero
//
// Build option:
//   FIXED_DIV_SAT_EN  saturate the result on overflow (default: keep low W bits).
module fixed_div #(
   parameter int INT_DIGIT     = 11,
   parameter int DECIMAL_DIGIT = 5
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [INT_DIGIT+DECIMAL_DIGIT-1:0] a,
   input  logic [INT_DIGIT+DECIMAL_DIGIT-1:0] b,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [INT_DIGIT+DECIMAL_DIGIT-1:0] result,
   output logic                               overflow,
   output logic                               div0
);

   localparam int W  = INT_DIGIT + DECIMAL_DIGIT;
   localparam int F  = DECIMAL_DIGIT;
   localparam int N  = W + F;
   localparam int CW = $clog2(N);

   localparam logic [N-1:0] QPOS = N'((2 ** (W - 1)) - 1);
   localparam logic [N-1:0] QNEG = N'(2 ** (W - 1));
   localparam logic [W-1:0] SMAX = {1'b0, {(W - 1){1'b1}}};
   localparam logic [W-1:0] SMIN = {1'b1, {(W - 1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t state;
   state_t state_n;

   logic [CW-1:0] cnt;
   logic [N-1:0]  dvd;
   logic [W:0]    rem;
   logic [W-1:0]  dsr;
   logic          sign;
   logic          bzero;

   logic [W-1:0]  abs_a;
   logic [W-1:0]  abs_b;

   logic [W+1:0]  rem_sh;
   logic          take;
   logic [W:0]    rem_n;
   logic [N-1:0]  dvd_n;

   logic [W-1:0]  qlo;
   logic [W-1:0]  res_n;
   logic          ovf_n;

   // ------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_n = CALC;
            end
         end
         CALC: begin
            if (cnt == '0) begin
               state_n = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------
   // Operand magnitudes (unsigned, so -2^(W-1) maps to 2^(W-1))
   // ------------------------------------------------------------
   always_comb begin
      abs_a = a[W-1] ? -a : a;
      abs_b = b[W-1] ? -b : b;
   end

   // ------------------------------------------------------------
   // One restoring step: quotient bits shift into the dividend
   // register from the bottom as dividend bits leave at the top.
   // ------------------------------------------------------------
   always_comb begin
      rem_sh = {rem, dvd[N-1]};
      take   = (rem_sh >= {2'b00, dsr});
      if (take) begin
         rem_n = (W + 1)'(rem_sh - {2'b00, dsr});
      end else begin
         rem_n = rem_sh[W:0];
      end
      dvd_n = {dvd[N-2:0], take};
   end

   // ------------------------------------------------------------
   // Finalise from the completed quotient magnitude dvd_n.
   // Low W bits of the signed quotient are the negated low bits.
   // ------------------------------------------------------------
   always_comb begin
      qlo   = dvd_n[W-1:0];
      ovf_n = sign ? (dvd_n > QNEG) : (dvd_n > QPOS);
      res_n = sign ? -qlo : qlo;
`ifdef FIXED_DIV_SAT_EN
      if (ovf_n) begin
         res_n = sign ? SMIN : SMAX;
      end
`endif
      if (bzero) begin
         ovf_n = 1'b0;
         res_n = sign ? SMIN : SMAX;
      end
   end

   // ------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         dvd      <= '0;
         rem      <= '0;
         dsr      <= '0;
         sign     <= 1'b0;
         bzero    <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
         div0     <= 1'b0;
      end else begin
         if (state == IDLE && in_valid) begin
            cnt   <= CW'(N - 1);
            dvd   <= {abs_a, {F{1'b0}}};
            rem   <= '0;
            dsr   <= abs_b;
            sign  <= a[W-1] ^ b[W-1];
            bzero <= (b == '0);
         end else if (state == CALC) begin
            cnt <= cnt - CW'(1);
            dvd <= dvd_n;
            rem <= rem_n;
            if (cnt == '0) begin
               result   <= res_n;
               overflow <= ovf_n;
               div0     <= bzero;
            end
         end
      end
   end

endmodule

// File: tb/tb_fixed_div.sv
// Randomised and directed bench for fixed_div (W=16, F=5).
// Checks results against an arithmetic reference model.
module tb_fixed_div;

   localparam int W = 16;
   localparam int F = 5;
   localparam int N = W + F;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          overflow;
   logic          div0;

   int checks = 0;
   int errors = 0;

   fixed_div #(
      .INT_DIGIT    (11),
      .DECIMAL_DIGIT(5)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result   (result),
      .overflow (overflow),
      .div0     (div0)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: {div0, overflow, result}
   function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                          input logic [W-1:0] y);
      longint sa, sb, ma, mb, q, v;
      bit neg, ov;
      logic [W-1:0] r;
      sa = longint'($signed(x));
      sb = longint'($signed(y));
      if (sb == 0) begin
         r = (sa < 0) ? 16'h8000 : 16'h7FFF;
         return {1'b1, 1'b0, r};
      end
      neg = (sa < 0) != (sb < 0);
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      q = (ma * (longint'(1) << F)) / mb;
      ov = neg ? (q > 32768) : (q > 32767);
      v = neg ? -q : q;
`ifdef FIXED_DIV_SAT_EN
      if (ov) v = neg ? -32768 : 32767;
`endif
      r = v[W-1:0];
      return {1'b0, ov, r};
   endfunction

   // Issue one op, check latency, result, flags, backpressure, handoff.
   task automatic run_op(input logic [W-1:0] opa, input logic [W-1:0] opb,
                         input int hold);
      int k;
      logic [W+1:0] exp;
      logic [W-1:0] r0;
      logic o0, z0;
      exp = model(opa, opb);
      @(negedge clk);
      k = 0;
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("ready_wait", 32'(in_ready), 32'd1);
      a = opa;
      b = opb;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      k = 0;
      while (!out_valid && k < 100) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      check("latency", 32'(k), 32'(N));
      check("result", 32'(result), 32'(exp[W-1:0]));
      check("overflow", 32'(overflow), 32'(exp[W]));
      check("div0", 32'(div0), 32'(exp[W+1]));
      r0 = result;
      o0 = overflow;
      z0 = div0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_busy", 32'(in_ready), 32'd0);
         check("hold_stable", {14'd0, z0, o0, r0},
               {14'd0, div0, overflow, result});
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("handoff_valid", 32'(out_valid), 32'd0);
      check("handoff_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic direct(input string tag, input logic [W-1:0] exp);
      check(tag, 32'(result), 32'(exp));
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int mode;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", {30'd0, overflow, div0}, 32'd0);

      run_op(16'h0060, 16'h0040, 0);
      direct("d_3div2", 16'h0030);
      run_op(16'hFFA0, 16'h0040, 0);
      direct("d_m3div2", 16'hFFD0);
      run_op(16'h0020, 16'h0060, 0);
      direct("d_1div3", 16'h000A);
      run_op(16'h0020, 16'h0000, 0);
      direct("d_pos_div0", 16'h7FFF);
      check("d_div0_flag", 32'(div0), 32'd1);
      run_op(16'hFFE0, 16'h0000, 0);
      direct("d_neg_div0", 16'h8000);
      run_op(16'h7FFF, 16'h0001, 0);
      check("d_ovf_flag", 32'(overflow), 32'd1);
`ifdef FIXED_DIV_SAT_EN
      direct("d_ovf_res", 16'h7FFF);
`else
      direct("d_ovf_res", 16'hFFE0);
`endif
      run_op(16'h0060, 16'h0040, 10);
      run_op(16'h8000, 16'h0020, 0);
      run_op(16'h8000, 16'hFFE0, 0);
      run_op(16'h0040, 16'h0020, 0);

      // Reset in the middle of a calculation
      @(negedge clk);
      a = 16'h0060;
      b = 16'h0040;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready", 32'(in_ready), 32'd1);
      check("midrst_valid", 32'(out_valid), 32'd0);
      run_op(16'h0040, 16'h0020, 0);
      direct("d_after_rst", 16'h0040);

      for (int n = 0; n < 200; n++) begin
         mode = $urandom_range(0, 9);
         ra = $urandom;
         rb = $urandom;
         if (mode == 0) rb = '0;
         if (mode == 1) rb = 16'($urandom_range(1, 3));
         if (mode == 2) rb = -16'($urandom_range(1, 3));
         if (mode == 3) ra = 16'h8000;
         if (mode == 4) rb = 16'h8000;
         run_op(ra, rb, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
